pc_sequencer: RTL and testbench

Fetch/execute sequencer for the Hack CPU, driving the 16-bit program counter's `load`/`inc`/`reset` controls. It fetches each instruction from ROM over a ready handshake, latches it into an instruction register and strobes execution. It then chooses between PC increment and jump from the C-instruction jump bits and the ALU `zr`/`ng` flags. It also detects halt (jump-to-self) and ROM-stall faults. It sits between the ROM, the ALU flags, the A register and the PC.

---
 rtl/pc_sequencer_pkg.sv | 26 ++
 rtl/pc_sequencer_jump_cond.sv | 28 ++
 rtl/pc_sequencer.sv | 118 +++++++++++
 tb/tb_pc_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the Hack fetch/execute sequencer: state encoding
// and C-instruction field positions.
`default_nettype none

package pc_sequencer_pkg;

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_HALT  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  // Instruction field positions
  localparam int IS_C = 15;
  localparam int J1   = 2;
  localparam int J2   = 1;
  localparam int J3   = 0;

  localparam int STALL_W = 8;
  localparam int WORD_W  = 16;

endpackage

`default_nettype wire

// File: rtl/pc_sequencer_jump_cond.sv
// Jump condition for a Hack C-instruction: the three jump bits select among
// the less-than / equal / greater-than outcomes of the ALU result.
`default_nettype none

module jump_cond
  import pc_sequencer_pkg::*;
(
  input  logic       is_c,
  input  logic [2:0] jbits,
  input  logic       zr,
  input  logic       ng,
  output logic       take
);

  logic lt;
  logic eq;
  logic gt;

  assign lt = ng;
  assign eq = zr;
  assign gt = ~ng & ~zr;

  // jbits indices coincide with the instruction bit positions J1..J3
  assign take = is_c & ((jbits[J1] & lt) | (jbits[J2] & eq) | (jbits[J3] & gt));

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// Hack CPU fetch/execute sequencer: ROM fetch handshake, instruction register,
// jump/increment decision, halt (jump-to-self) and ROM-stall fault detection.
`default_nettype none

module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [WORD_W-1:0]  rom_data,
  input  logic               rom_ready,
  input  logic               zr,
  input  logic               ng,
  input  logic [WORD_W-1:0]  a_reg,
  input  logic [WORD_W-1:0]  pc_out,
  output logic               rom_req,
  output logic [WORD_W-1:0]  ir,
  output logic               exec_en,
  output logic [WORD_W-1:0]  pc_in,
  output logic               pc_load,
  output logic               pc_inc,
  output logic               pc_reset,
  output logic               halted,
  output logic               fault,
  output logic [WORD_W-1:0]  instr_count
);

  localparam logic [STALL_W-1:0] TIMEOUT_C = TIMEOUT[STALL_W-1:0];

  state_t             state;
  state_t             state_next;
  logic [STALL_W-1:0] stall_cnt;
  logic [STALL_W-1:0] stall_inc;
  logic               take;

  assign stall_inc = stall_cnt + 1'b1;
  assign pc_in     = a_reg;

  jump_cond u_jump_cond (
    .is_c  (ir[IS_C]),
    .jbits (ir[J1:J3]),
    .zr    (zr),
    .ng    (ng),
    .take  (take)
  );

  always_comb begin
    state_next = state;
    rom_req    = 1'b0;
    exec_en    = 1'b0;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_reset   = 1'b0;
    halted     = 1'b0;
    fault      = 1'b0;
    case (state)
      S_RESET: begin
        pc_reset   = 1'b1;
        state_next = S_FETCH;
      end
      S_FETCH: begin
        rom_req = 1'b1;
        if (rom_ready) begin
          state_next = S_EXEC;
        end else if (stall_inc == TIMEOUT_C) begin
          state_next = S_FAULT;
        end
      end
      S_EXEC: begin
        exec_en = 1'b1;
        if (take) begin
          pc_load = 1'b1;
          // A taken jump whose target is the current PC can never make progress
          state_next = (a_reg == pc_out) ? S_HALT : S_FETCH;
        end else begin
          pc_inc     = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: state_next = S_RESET;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_RESET;
      ir          <= '0;
      instr_count <= '0;
      stall_cnt   <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_RESET: begin
          ir          <= '0;
          instr_count <= '0;
          stall_cnt   <= '0;
        end
        S_FETCH: begin
          if (rom_ready) begin
            ir        <= rom_data;
            stall_cnt <= '0;
          end else begin
            stall_cnt <= stall_inc;
          end
        end
        S_EXEC:  instr_count <= instr_count + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: behavioural model plus directed vectors.
`default_nettype none

module tb_pc_sequencer;

  localparam int TIMEOUT = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] rom_data;
  logic        rom_ready;
  logic        zr;
  logic        ng;
  logic [15:0] a_reg;
  logic [15:0] pc_out;
  logic        rom_req;
  logic [15:0] ir;
  logic        exec_en;
  logic [15:0] pc_in;
  logic        pc_load;
  logic        pc_inc;
  logic        pc_reset;
  logic        halted;
  logic        fault;
  logic [15:0] instr_count;

  pc_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clock       (clock),
    .reset       (reset),
    .rom_data    (rom_data),
    .rom_ready   (rom_ready),
    .zr          (zr),
    .ng          (ng),
    .a_reg       (a_reg),
    .pc_out      (pc_out),
    .rom_req     (rom_req),
    .ir          (ir),
    .exec_en     (exec_en),
    .pc_in       (pc_in),
    .pc_load     (pc_load),
    .pc_inc      (pc_inc),
    .pc_reset    (pc_reset),
    .halted      (halted),
    .fault       (fault),
    .instr_count (instr_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Jump bits are a mask over the {less, equal, greater} outcome of the ALU.
  function automatic logic spec_take(input logic [15:0] i, input logic z, input logic n);
    logic [2:0] outcome;
    outcome = {n, z, (!n && !z)};
    return i[15] && (|(i[2:0] & outcome));
  endfunction

  // Model: phase of the instruction cycle plus architectural registers.
  localparam int M_RST = 0, M_FETCH = 1, M_EXEC = 2, M_HALT = 3, M_FAULT = 4;
  int          mode = -1;
  logic [15:0] m_ir;
  logic [15:0] m_count;
  int          m_stall;

  always @(posedge clock) begin
    if (reset) begin
      mode <= M_RST; m_ir <= 16'h0; m_count <= 16'h0; m_stall <= 0;
    end else begin
      case (mode)
        M_RST: begin
          mode <= M_FETCH; m_ir <= 16'h0; m_count <= 16'h0; m_stall <= 0;
        end
        M_FETCH: begin
          if (rom_ready) begin
            m_ir <= rom_data; m_stall <= 0; mode <= M_EXEC;
          end else begin
            m_stall <= m_stall + 1;
            if (m_stall + 1 >= TIMEOUT) mode <= M_FAULT;
          end
        end
        M_EXEC: begin
          m_count <= m_count + 16'd1;
          if (spec_take(m_ir, zr, ng) && a_reg == pc_out) mode <= M_HALT;
          else mode <= M_FETCH;
        end
        default: ;
      endcase
    end
  end

  always @(negedge clock) begin
    #4;
    if (mode >= 0) begin
      chk("m_rom_req",  {31'd0, rom_req},  {31'd0, mode == M_FETCH});
      chk("m_exec_en",  {31'd0, exec_en},  {31'd0, mode == M_EXEC});
      chk("m_pc_load",  {31'd0, pc_load},  {31'd0, mode == M_EXEC && spec_take(m_ir, zr, ng)});
      chk("m_pc_inc",   {31'd0, pc_inc},   {31'd0, mode == M_EXEC && !spec_take(m_ir, zr, ng)});
      chk("m_pc_reset", {31'd0, pc_reset}, {31'd0, mode == M_RST});
      chk("m_halted",   {31'd0, halted},   {31'd0, mode == M_HALT});
      chk("m_fault",    {31'd0, fault},    {31'd0, mode == M_FAULT});
      chk("m_ir",       {16'd0, ir},       {16'd0, m_ir});
      chk("m_count",    {16'd0, instr_count}, {16'd0, m_count});
      chk("m_pc_in",    {16'd0, pc_in},    {16'd0, a_reg});
    end
  end

  logic snap_load, snap_inc, snap_exec, snap_fault;

  // Entered just after a falling edge with the DUT in FETCH; returns likewise.
  task automatic fetch_exec(input logic [15:0] d, input logic z, input logic n,
                            input logic [15:0] a, input logic [15:0] pcv);
    rom_ready = 1'b1; rom_data = d; pc_out = pcv; a_reg = a;
    @(negedge clock);
    zr = z; ng = n;
    #4;
    snap_load = pc_load; snap_inc = pc_inc; snap_exec = exec_en; snap_fault = fault;
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; rom_ready = 1'b1; rom_data = 16'h0; zr = 1'b0; ng = 1'b0;
    a_reg = 16'h0100; pc_out = 16'h0;

    // Reset held two cycles, then first fetch
    @(negedge clock); #4;
    chk("reset_pc_reset", {31'd0, pc_reset}, 32'd1);
    chk("reset_rom_req",  {31'd0, rom_req},  32'd0);
    @(negedge clock); reset = 1'b0;
    @(negedge clock); #4;
    chk("first_rom_req", {31'd0, rom_req}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      fetch_exec(16'h0005 + 16'(i), 1'b0, 1'b0, 16'h0100, 16'(i));
      if (i == 0) chk("first_exec_en", {31'd0, snap_exec}, 32'd1);
    end
    #4;
    chk("count_after_5", {16'd0, instr_count}, 32'd5);
    chk("ir_after_5",    {16'd0, ir},          32'h0009);

    // JEQ taken / not taken
    fetch_exec(16'hE302, 1'b1, 1'b0, 16'h0200, 16'h0005);
    chk("jeq_zr_load", {31'd0, snap_load}, 32'd1);
    fetch_exec(16'hE302, 1'b0, 1'b0, 16'h0200, 16'h0006);
    chk("jeq_pos_inc",  {31'd0, snap_inc},  32'd1);
    chk("jeq_pos_load", {31'd0, snap_load}, 32'd0);

    // Sweep every jump code against (zr,ng) = 00, 01, 10
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 3; f++) begin
        fetch_exec({13'h1C60, c[2:0]}, (f == 2), (f == 1), 16'h0400, 16'h0030);
        if (c == 7) chk("jmp_always_load", {31'd0, snap_load}, 32'd1);
        if (c == 0) chk("null_always_inc", {31'd0, snap_inc},  32'd1);
      end
    end

    // A-instruction never jumps
    fetch_exec(16'h0007, 1'b1, 1'b0, 16'h0300, 16'h0007);
    chk("ainst_inc",  {31'd0, snap_inc},  32'd1);
    chk("ainst_load", {31'd0, snap_load}, 32'd0);

    // Jump-to-self halts
    fetch_exec(16'hEA87, 1'b0, 1'b0, 16'h0010, 16'h0010);
    chk("halt_load", {31'd0, snap_load}, 32'd1);
    #4;
    chk("halted",         {31'd0, halted},  32'd1);
    chk("halt_no_req",    {31'd0, rom_req}, 32'd0);
    @(negedge clock); #4;
    chk("halt_stays",     {31'd0, halted},  32'd1);
    reset = 1'b1;
    @(negedge clock); #4;
    chk("halt_reset_pc_reset", {31'd0, pc_reset}, 32'd1);
    chk("halt_reset_cleared",  {31'd0, halted},   32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Three not-ready cycles then accept
    rom_ready = 1'b0;
    repeat (3) @(negedge clock);
    #4;
    chk("wait_still_fetch", {31'd0, rom_req}, 32'd1);
    fetch_exec(16'h1234, 1'b0, 1'b0, 16'h0100, 16'h0002);
    chk("wait_accept_exec", {31'd0, snap_exec},  32'd1);
    chk("wait_no_fault",    {31'd0, snap_fault}, 32'd0);

    // Eight not-ready cycles then fault
    rom_ready = 1'b0;
    repeat (7) @(negedge clock);
    #4;
    chk("fault_not_early", {31'd0, fault}, 32'd0);
    @(negedge clock); #4;
    chk("fault_cycle9",    {31'd0, fault},   32'd1);
    chk("fault_no_req",    {31'd0, rom_req}, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; rom_ready = 1'b1;
    @(negedge clock);

    // Reset during EXEC of a taken jump
    rom_data = 16'hE307; rom_ready = 1'b1;
    @(negedge clock);
    zr = 1'b0; ng = 1'b0; a_reg = 16'h0300; pc_out = 16'h0020; reset = 1'b1;
    #4;
    chk("midop_load", {31'd0, pc_load}, 32'd1);
    @(negedge clock);
    reset = 1'b0;
    #4;
    chk("midop_pc_reset", {31'd0, pc_reset},       32'd1);
    chk("midop_count",    {16'd0, instr_count},    32'd0);
    chk("midop_no_exec",  {31'd0, exec_en},        32'd0);
    @(negedge clock);
    fetch_exec(16'h0001, 1'b0, 1'b0, 16'h0100, 16'h0000);
    #4;
    chk("after_midop_count", {16'd0, instr_count}, 32'd1);

    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
